// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command sequencer: default widths,
// the downstream "hold" function code and the sequencer state encoding.
package alu_cmd_pkg;

    localparam int DEPTH_DEF  = 4;
    localparam int DATA_W_DEF = 4;
    localparam int FUNC_W_DEF = 3;

    localparam logic [2:0] FUNC_HOLD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command-side and ALU-side signal bundle for the sequencer; the master
// modport is the command producer, the slave modport is the sequencer.
interface alu_cmd_if #(
    parameter int DATA_W = alu_cmd_pkg::DATA_W_DEF,
    parameter int FUNC_W = alu_cmd_pkg::FUNC_W_DEF
);
    import alu_cmd_pkg::*;

    logic              In_valid;
    logic              In_ready;
    logic [DATA_W-1:0] In_data;
    logic [FUNC_W-1:0] In_func;
    logic [DATA_W-1:0] Data;
    logic [FUNC_W-1:0] Function;
    logic              Issued;

    modport master (
        output In_valid, In_data, In_func,
        input  In_ready, Data, Function, Issued
    );

    modport slave (
        input  In_valid, In_data, In_func,
        output In_ready, Data, Function, Issued
    );

endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Power-of-two circular command buffer with occupancy count; push is
// ignored when full and pop is ignored when empty.
module cmd_fifo #(
    parameter int DEPTH = alu_cmd_pkg::DEPTH_DEF,
    parameter int WIDTH = alu_cmd_pkg::DATA_W_DEF + alu_cmd_pkg::FUNC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    import alu_cmd_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_MAX);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage is deliberately left unreset; stale entries sit behind the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues {function, operand} commands and issues them to the ALU stage,
// either continuously (Run level) or one at a time (Step rising edge).
module alu_cmd_sequencer #(
    parameter int DEPTH  = alu_cmd_pkg::DEPTH_DEF,
    parameter int DATA_W = alu_cmd_pkg::DATA_W_DEF,
    parameter int FUNC_W = alu_cmd_pkg::FUNC_W_DEF
) (
    input  logic                   Clock,
    input  logic                   Reset_b,
    input  logic                   In_valid,
    output logic                   In_ready,
    input  logic [DATA_W-1:0]      In_data,
    input  logic [FUNC_W-1:0]      In_func,
    input  logic                   Run,
    input  logic                   Step,
    output logic [DATA_W-1:0]      Data,
    output logic [FUNC_W-1:0]      Function,
    output logic                   Issued,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Empty,
    output logic                   Full
);
    import alu_cmd_pkg::*;

    localparam int ENTRY_W = FUNC_W + DATA_W;
    localparam logic [FUNC_W-1:0] HOLD = FUNC_W'(FUNC_HOLD);

    seq_state_t             r_state;
    seq_state_t             w_next_state;
    logic                   r_step_d;
    logic                   w_step_pulse;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_empty;
    logic                   w_full;
    logic [ENTRY_W-1:0]     w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic [DATA_W-1:0]      r_data;
    logic [FUNC_W-1:0]      r_func;
    logic                   r_issued;

    assign In_ready     = ~w_full;
    assign w_push       = In_valid & ~w_full;
    assign w_step_pulse = Step & ~r_step_d;

    assign Count    = w_count;
    assign Empty    = w_empty;
    assign Full     = w_full;
    assign Data     = r_data;
    assign Function = r_func;
    assign Issued   = r_issued;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (Reset_b),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({In_func, In_data}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            r_state  <= IDLE;
            r_step_d <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_step_d <= Step;
        end
    end

    // Run outranks Step everywhere; STEP only leaves once it has actually popped.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (Run) begin
                    w_next_state = RUN;
                end else if (w_step_pulse) begin
                    w_next_state = STEP;
                end
            end
            RUN: begin
                if (!Run) begin
                    w_next_state = IDLE;
                end
            end
            STEP: begin
                if (Run) begin
                    w_next_state = RUN;
                end else if (!w_empty) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_pop = 1'b0;
        if (!w_empty && (r_state == RUN || r_state == STEP)) begin
            w_pop = 1'b1;
        end
    end

    // Idle cycles present the hold code so the ALU stage treats them as no-ops.
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            r_data   <= '0;
            r_func   <= HOLD;
            r_issued <= 1'b0;
        end else if (w_pop) begin
            r_data   <= w_head[DATA_W-1:0];
            r_func   <= w_head[ENTRY_W-1:DATA_W];
            r_issued <= 1'b1;
        end else begin
            r_data   <= '0;
            r_func   <= HOLD;
            r_issued <= 1'b0;
        end
    end

endmodule
